i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/i2c_slave.sv | 163 ++++++++++++++++
 tb/tb_i2c_slave.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg -- definitions shared by the I2C slave and the I2C master.
//   i2c_state_e : one-hot protocol states (IDLE .. IGNORE)
//   BYTE_BITS   : bits per byte on the wire
//   SDA_ACK/NACK: bus levels for the acknowledge bit
//   ack_oe()    : pad output-enable needed to put a given level on sda
package i2c_pkg;

  localparam int BYTE_BITS = 8;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  typedef enum logic [7:0] {
    ST_IDLE    = 8'b0000_0001,
    ST_DEVADDR = 8'b0000_0010,
    ST_DEVACK  = 8'b0000_0100,
    ST_REGADDR = 8'b0000_1000,
    ST_REGACK  = 8'b0001_0000,
    ST_DATA    = 8'b0010_0000,
    ST_DATAACK = 8'b0100_0000,
    ST_IGNORE  = 8'b1000_0000
  } i2c_state_e;

  // Open-drain pad: only a low level is driven, a high level is a release.
  function automatic logic ack_oe(input logic level);
    return (level == SDA_ACK) && (level != SDA_NACK);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge -- 2-flop synchronizer for one bus line plus edge pulses.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset (flops go to idle bus level 1)
//   d_i     : asynchronous bus line
//   level_o : synchronized level
//   rise_o  : one-clk pulse on a synchronized 0->1 transition
//   fall_o  : one-clk pulse on a synchronized 1->0 transition
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] metastability flop, [1] synchronized level, [2] previous level
  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    // NOTE: reset to the idle bus level (1), not 0, so releasing reset
    // cannot manufacture an sda falling edge that looks like a START.
    if (rst_i) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], d_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  =  sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave -- write-only I2C register-bus slave, oversampled by clk.
//   clk       : system clock (scl is only sampled, never used as a clock)
//   rst       : synchronous active-high reset
//   scl_in    : bus clock from the master
//   sda_in    : resolved bus data line
//   sda_oe    : 1 pulls sda low (ACK), 0 releases it
//   reg_addr  : register address of the current write (auto-increments)
//   reg_wdata : received data byte
//   reg_wr_en : one-clk strobe qualifying reg_addr/reg_wdata
//   busy      : high from START until STOP or reset
//   ack_err   : sticky, set when a read to this address is NACKed
// DATA_WIDTH is expected to be at least BYTE_BITS; the device-address
// byte always occupies the low BYTE_BITS of the shift register.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDRESS = 7'h50,
  parameter int         DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [DATA_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr_en,
  output logic                  busy,
  output logic                  ack_err
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (scl_in),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (sda_in),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e            state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_en_q;
  logic                  oe_q;
  logic                  busy_q;
  logic                  ack_err_q;

  logic                  start_det, stop_det, byte_done;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [BYTE_BITS-1:0]  dev_byte;
  logic                  addr_match;

  assign start_det  = sda_fall & scl_lvl;
  assign stop_det   = sda_rise & scl_lvl;
  assign shift_d    = {shift_q[DATA_WIDTH-2:0], sda_lvl};
  assign byte_done  = scl_rise && (cnt_q == CNT_LAST);
  assign dev_byte   = shift_d[BYTE_BITS-1:0];
  assign addr_match = (dev_byte[BYTE_BITS-1:1] == SLV_ADDRESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      // NOTE: default first; a later non-blocking assignment in this block
      // overrides it, which is what makes wr_en_q a single-cycle pulse.
      wr_en_q <= 1'b0;

      // Address advances only after the strobe cycle, so the strobe sees
      // the address the byte was written to.
      if (wr_en_q) addr_q <= addr_q + 1'b1;

      // Bus conditions outrank scl edges; a partial byte is simply dropped.
      if (start_det) begin
        state_q <= ST_DEVADDR;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else if (stop_det) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_DEVADDR, ST_REGADDR, ST_DATA: begin
            if (scl_rise) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 1'b1;
            end
            if (byte_done) begin
              cnt_q <= '0;
              if (state_q == ST_DEVADDR) begin
                if (addr_match && dev_byte[0] == 1'b0) begin
                  state_q <= ST_DEVACK;
                end else begin
                  // Reads are not supported: NACK and remember it.
                  if (addr_match) ack_err_q <= 1'b1;
                  state_q <= ST_IGNORE;
                end
              end else if (state_q == ST_REGADDR) begin
                addr_q  <= shift_d;
                state_q <= ST_REGACK;
              end else begin
                wdata_q <= shift_d;
                wr_en_q <= 1'b1;
                state_q <= ST_DATAACK;
              end
            end
          end

          // First scl fall after the byte drives ACK, the second releases
          // it, so the master sees it for exactly one scl high period.
          ST_DEVACK, ST_REGACK, ST_DATAACK: begin
            if (scl_fall) begin
              if (!oe_q) begin
                oe_q <= ack_oe(SDA_ACK);
              end else begin
                oe_q    <= 1'b0;
                state_q <= (state_q == ST_DEVACK) ? ST_REGADDR : ST_DATA;
              end
            end
          end

          default: ;  // IDLE and IGNORE only leave on START/STOP
        endcase
      end
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
  assign busy      = busy_q;
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave -- directed bench for i2c_slave with a write scoreboard.
// clk period 10 ns; scl runs at clk/20 (10 clks low, 10 clks high).
// The master model drives inputs on clk falling edges; expected register
// writes are queued by the stimulus and popped by a separate monitor.
module tb_i2c_slave;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       busy;
  logic       ack_err;

  // Open-drain wired-AND of master and slave.
  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave #(.SLV_ADDRESS(7'h50), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .busy     (busy),
    .ack_err  (ack_err)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  oe_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(5);
    scl   = 1'b1; wait_clk(5);
    sda_m = 1'b0; wait_clk(5);
    scl   = 1'b0; wait_clk(5);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(5);
    scl   = 1'b1; wait_clk(5);
    sda_m = 1'b1; wait_clk(10);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(5);
    scl   = 1'b1; wait_clk(10);
    scl   = 1'b0; wait_clk(5);
  endtask

  // Eight data bits then the acknowledge clock; the ACK must cover the
  // whole scl high period and be released shortly after scl falls.
  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    int hi;
    hi = 0;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; wait_clk(5);
    scl   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sda_oe) hi++;
      wait_clk(1);
    end
    scl = 1'b0; wait_clk(5);
    check({name, "_ack"}, hi, exp_ack ? 10 : 0);
    check({name, "_rel"}, sda_oe, 1'b0);
  endtask

  // Monitor: every strobe must match the oldest queued write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (sda_oe) oe_cycles++;
      if (reg_wr_en) begin
        check("wr_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("wr_addr", reg_addr, w.addr);
          check("wr_data", reg_wdata, w.data);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_before;

    // Reset state
    wait_clk(4);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_wr_en",  reg_wr_en, 1'b0);
    check("rst_busy",   busy, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_addr",   reg_addr, 8'h00);
    check("rst_wdata",  reg_wdata, 8'h00);
    rst = 1'b0;
    wait_clk(5);
    check("idle_busy", busy, 1'b0);

    // Basic write: dev 0xA0, reg 0x10, data 0x5A
    expect_wr(8'h10, 8'h5A);
    bus_start();
    check("t1_busy_start", busy, 1'b1);
    send_byte(8'hA0, 1'b1, "t1_dev");
    send_byte(8'h10, 1'b1, "t1_reg");
    send_byte(8'h5A, 1'b1, "t1_data");
    check("t1_busy_mid", busy, 1'b1);
    bus_stop();
    check("t1_busy_stop", busy, 1'b0);
    check("t1_addr_inc", reg_addr, 8'h11);

    // Address mismatch: no ACK anywhere, parked in IGNORE until STOP
    oe_before = oe_cycles;
    bus_start();
    send_byte(8'hA2, 1'b0, "t2_dev");
    send_byte(8'h10, 1'b0, "t2_b2");
    check("t2_state_ignore", dut.state_q, ST_IGNORE);
    bus_stop();
    check("t2_state_idle", dut.state_q, ST_IDLE);
    check("t2_oe_cycles", oe_cycles - oe_before, 0);
    check("t2_busy", busy, 1'b0);

    // Address wrap across a multi-byte write
    expect_wr(8'hFF, 8'h11);
    expect_wr(8'h00, 8'h22);
    bus_start();
    send_byte(8'hA0, 1'b1, "t3_dev");
    send_byte(8'hFF, 1'b1, "t3_reg");
    send_byte(8'h11, 1'b1, "t3_d0");
    send_byte(8'h22, 1'b1, "t3_d1");
    bus_stop();
    check("t3_addr_after", reg_addr, 8'h01);
    check("t3_ack_err", ack_err, 1'b0);

    // Read request: NACK and sticky ack_err
    bus_start();
    send_byte(8'hA1, 1'b0, "t4_dev");
    check("t4_ack_err", ack_err, 1'b1);
    bus_stop();
    check("t4_ack_err_stop", ack_err, 1'b1);

    // STOP after four data bits, then a clean write
    bus_start();
    send_byte(8'hA0, 1'b1, "t5_dev");
    send_byte(8'h40, 1'b1, "t5_reg");
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    bus_stop();
    check("t5_busy_abort", busy, 1'b0);
    expect_wr(8'h20, 8'h33);
    bus_start();
    send_byte(8'hA0, 1'b1, "t5b_dev");
    send_byte(8'h20, 1'b1, "t5b_reg");
    send_byte(8'h33, 1'b1, "t5b_data");
    bus_stop();
    check("t5_ack_err_sticky", ack_err, 1'b1);

    // Reset while the device-address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(8'hA0 >> i);
    check("t6_oe_before_rst", sda_oe, 1'b1);
    rst = 1'b1;
    wait_clk(1);
    check("t6_oe_after_rst", sda_oe, 1'b0);
    check("t6_busy_after_rst", busy, 1'b0);
    check("t6_ack_err_cleared", ack_err, 1'b0);
    rst = 1'b0;
    sda_m = 1'b1; wait_clk(5);
    scl   = 1'b1; wait_clk(10);
    // Without a fresh START the slave must stay silent
    send_byte(8'hA0, 1'b0, "t6_nostart");
    sda_m = 1'b1; wait_clk(5);
    scl   = 1'b1; wait_clk(10);
    expect_wr(8'h30, 8'h77);
    bus_start();
    send_byte(8'hA0, 1'b1, "t6_dev");
    send_byte(8'h30, 1'b1, "t6_reg");
    send_byte(8'h77, 1'b1, "t6_data");
    bus_stop();
    check("t6_busy_end", busy, 1'b0);

    wait_clk(10);
    check("wr_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
